// File: rtl/axil2lb.sv
// axil2lb: AXI4-Lite slave to local-bus bridge.
// Converts AXI4-Lite write/read transactions into single local-bus accesses.
// The write and read paths are independent FSMs and may be active at the same time.
// Each direction has at most one transaction in flight.
// Every output is registered.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   axil_aw*/axil_w*/axil_b*        AXI4-Lite write address, data and response channels
//   axil_ar*/axil_r*                AXI4-Lite read address and data channels
//   lb_waddr/lb_wdata/lb_wstrb      local-bus write payload
//   lb_wen/lb_wready                local-bus write request/accept
//   lb_raddr/lb_ren                 local-bus read address/request
//   lb_rdata/lb_rvalid              local-bus read data/valid
//
// Optional feature: define AXIL2LB_TIMEOUT_EN to bound local-bus waits.
// A wait longer than TIMEOUT_CYCLES ends the access with an SLVERR response.
module axil2lb #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned STRB_W         = DATA_W / 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] axil_awaddr,
    input  logic              axil_awvalid,
    output logic              axil_awready,
    input  logic [DATA_W-1:0] axil_wdata,
    input  logic [STRB_W-1:0] axil_wstrb,
    input  logic              axil_wvalid,
    output logic              axil_wready,
    output logic [1:0]        axil_bresp,
    output logic              axil_bvalid,
    input  logic              axil_bready,
    input  logic [ADDR_W-1:0] axil_araddr,
    input  logic              axil_arvalid,
    output logic              axil_arready,
    output logic [DATA_W-1:0] axil_rdata,
    output logic [1:0]        axil_rresp,
    output logic              axil_rvalid,
    input  logic              axil_rready,
    output logic [ADDR_W-1:0] lb_waddr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic [STRB_W-1:0] lb_wstrb,
    output logic              lb_wen,
    input  logic              lb_wready,
    output logic [ADDR_W-1:0] lb_raddr,
    output logic              lb_ren,
    input  logic [DATA_W-1:0] lb_rdata,
    input  logic              lb_rvalid
);

    // Elaboration-time parameter sanity check
    if ((DATA_W % 8) != 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("axil2lb: DATA_W must be a multiple of 8 and TIMEOUT_CYCLES nonzero");
    end

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_LB, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LB, R_RESP} r_state_t;

    w_state_t w_state, w_state_d;
    r_state_t r_state, r_state_d;
    logic aw_have, aw_have_d, w_have, w_have_d;

    logic              awready_d, wready_d, bvalid_d, lb_wen_d;
    logic [1:0]        bresp_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [STRB_W-1:0] wstrb_d;
    logic              arready_d, rvalid_d, lb_ren_d;
    logic [1:0]        rresp_d;
    logic [ADDR_W-1:0] raddr_d;
    logic [DATA_W-1:0] rdata_d;

    logic aw_hs_c, w_hs_c, ar_hs_c, w_done_c, r_done_c, w_tmo_c, r_tmo_c;

    assign aw_hs_c  = axil_awvalid & axil_awready;
    assign w_hs_c   = axil_wvalid & axil_wready;
    assign ar_hs_c  = axil_arvalid & axil_arready;
    assign w_done_c = lb_wen & lb_wready;
    assign r_done_c = lb_ren & lb_rvalid;

`ifdef AXIL2LB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] w_cnt, r_cnt;

    // Wait counters idle at zero outside the LB states, so they clear on entry
    always_ff @(posedge clk) begin
        if (rst || w_state != W_LB) w_cnt <= '0;
        else                        w_cnt <= w_cnt + CNT_W'(1);
        if (rst || r_state != R_LB) r_cnt <= '0;
        else                        r_cnt <= r_cnt + CNT_W'(1);
    end

    assign w_tmo_c = (w_state == W_LB) && (w_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign r_tmo_c = (r_state == R_LB) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_c = 1'b0;
    assign r_tmo_c = 1'b0;
`endif

    // Write FSM state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state      <= W_IDLE;
            aw_have      <= 1'b0;
            w_have       <= 1'b0;
            axil_awready <= 1'b0;
            axil_wready  <= 1'b0;
            axil_bvalid  <= 1'b0;
            axil_bresp   <= '0;
            lb_wen       <= 1'b0;
            lb_waddr     <= '0;
            lb_wdata     <= '0;
            lb_wstrb     <= '0;
        end else begin
            w_state      <= w_state_d;
            aw_have      <= aw_have_d;
            w_have       <= w_have_d;
            axil_awready <= awready_d;
            axil_wready  <= wready_d;
            axil_bvalid  <= bvalid_d;
            axil_bresp   <= bresp_d;
            lb_wen       <= lb_wen_d;
            lb_waddr     <= waddr_d;
            lb_wdata     <= wdata_d;
            lb_wstrb     <= wstrb_d;
        end
    end

    // Write next state; AW and W are captured independently, in either order
    always_comb begin
        w_state_d = w_state;
        aw_have_d = aw_have;
        w_have_d  = w_have;
        case (w_state)
            W_IDLE: begin
                if (aw_hs_c) aw_have_d = 1'b1;
                if (w_hs_c)  w_have_d  = 1'b1;
                if (aw_have_d && w_have_d) begin
                    w_state_d = W_LB;
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                end
            end
            W_LB:    if (w_done_c || w_tmo_c) w_state_d = W_RESP;
            W_RESP:  if (axil_bvalid && axil_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write outputs, computed from the next state so they can be registered
    always_comb begin
        awready_d = (w_state_d == W_IDLE) && !aw_have_d;
        wready_d  = (w_state_d == W_IDLE) && !w_have_d;
        lb_wen_d  = (w_state_d == W_LB);
        bvalid_d  = (w_state_d == W_RESP);
        bresp_d   = axil_bresp;
        waddr_d   = lb_waddr;
        wdata_d   = lb_wdata;
        wstrb_d   = lb_wstrb;
        if (w_state == W_IDLE && aw_hs_c) waddr_d = axil_awaddr;
        if (w_state == W_IDLE && w_hs_c) begin
            wdata_d = axil_wdata;
            wstrb_d = axil_wstrb;
        end
        // A completion in the same cycle as the timeout reports OKAY
        if (w_state == W_LB && w_state_d == W_RESP)
            bresp_d = w_done_c ? RESP_OKAY : RESP_SLVERR;
    end

    // Read FSM state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= R_IDLE;
            axil_arready <= 1'b0;
            axil_rvalid  <= 1'b0;
            axil_rresp   <= '0;
            axil_rdata   <= '0;
            lb_ren       <= 1'b0;
            lb_raddr     <= '0;
        end else begin
            r_state      <= r_state_d;
            axil_arready <= arready_d;
            axil_rvalid  <= rvalid_d;
            axil_rresp   <= rresp_d;
            axil_rdata   <= rdata_d;
            lb_ren       <= lb_ren_d;
            lb_raddr     <= raddr_d;
        end
    end

    // Read next state
    always_comb begin
        r_state_d = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs_c) r_state_d = R_LB;
            R_LB:    if (r_done_c || r_tmo_c) r_state_d = R_RESP;
            R_RESP:  if (axil_rvalid && axil_rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read outputs
    always_comb begin
        arready_d = (r_state_d == R_IDLE);
        lb_ren_d  = (r_state_d == R_LB);
        rvalid_d  = (r_state_d == R_RESP);
        rresp_d   = axil_rresp;
        rdata_d   = axil_rdata;
        raddr_d   = lb_raddr;
        if (r_state == R_IDLE && ar_hs_c) raddr_d = axil_araddr;
        if (r_state == R_LB && r_state_d == R_RESP) begin
            rresp_d = r_done_c ? RESP_OKAY : RESP_SLVERR;
            rdata_d = r_done_c ? lb_rdata : '0;
        end
    end

endmodule

// File: tb/tb_axil2lb.sv
// tb_axil2lb: directed self-checking bench for axil2lb.
// The timeout checks are included when AXIL2LB_TIMEOUT_EN is defined.
// That build uses TIMEOUT_CYCLES = 8.
module tb_axil2lb;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [15:0] lb_waddr, lb_raddr;
    logic [31:0] lb_wdata, lb_rdata;
    logic [3:0]  lb_wstrb;
    logic        lb_wen, lb_wready, lb_ren, lb_rvalid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axil2lb #(.ADDR_W(16), .DATA_W(32), .STRB_W(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .axil_awaddr(awaddr), .axil_awvalid(awvalid), .axil_awready(awready),
        .axil_wdata(wdata), .axil_wstrb(wstrb), .axil_wvalid(wvalid), .axil_wready(wready),
        .axil_bresp(bresp), .axil_bvalid(bvalid), .axil_bready(bready),
        .axil_araddr(araddr), .axil_arvalid(arvalid), .axil_arready(arready),
        .axil_rdata(rdata), .axil_rresp(rresp), .axil_rvalid(rvalid), .axil_rready(rready),
        .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb), .lb_wen(lb_wen),
        .lb_wready(lb_wready), .lb_raddr(lb_raddr), .lb_ren(lb_ren),
        .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1; lb_wready = 1'b0; lb_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; lb_rdata = '0;
        idle_inputs();
        repeat (2) tick();
        n_checks++; if ({awready, wready, bvalid, arready, rvalid, lb_wen, lb_ren} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected 0000000",
                {awready, wready, bvalid, arready, rvalid, lb_wen, lb_ren}); end
        n_checks++; if ({bresp, rresp, rdata, lb_waddr, lb_wdata, lb_raddr} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0",
                {bresp, rresp, rdata, lb_waddr, lb_wdata, lb_raddr}); end
        rst = 1'b0;
        tick();
        n_checks++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 11100",
                {awready, wready, arready, bvalid, rvalid}); end
    endtask

    task automatic test_single_write();
        idle_inputs(); lb_wready = 1'b1;
        awaddr = 16'h0030; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n_checks++; if ({lb_wen, awready, wready} !== 3'b100) begin
            n_fail++; $display("FAIL sw_wen: got %b expected 100", {lb_wen, awready, wready}); end
        n_checks++; if ({lb_waddr, lb_wdata, lb_wstrb} !== {16'h0030, 32'hDEADBEEF, 4'hF}) begin
            n_fail++; $display("FAIL sw_payload: got %h/%h/%h expected 0030/deadbeef/f",
                lb_waddr, lb_wdata, lb_wstrb); end
        tick();
        n_checks++; if ({lb_wen, bvalid, bresp} !== 4'b0100) begin
            n_fail++; $display("FAIL sw_resp: got wen=%b bvalid=%b bresp=%b expected 0/1/00",
                lb_wen, bvalid, bresp); end
        tick();
        n_checks++; if ({bvalid, awready, wready} !== 3'b011) begin
            n_fail++; $display("FAIL sw_done: got %b expected 011", {bvalid, awready, wready}); end
    endtask

    task automatic test_w_before_aw();
        int wen_cycles = 0;
        idle_inputs();
        wdata = 32'h00000001; wstrb = 4'h5; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({wready, awready, lb_wen} !== 3'b010) begin
                n_fail++; $display("FAIL wfirst_wait%0d: got wready/awready/wen=%b expected 010",
                    i, {wready, awready, lb_wen}); end
            if (i == 2) begin awaddr = 16'h0030; awvalid = 1'b1; end
            tick();
        end
        awvalid = 1'b0;
        n_checks++; if ({lb_wen, lb_waddr, lb_wdata, lb_wstrb} !== {1'b1, 16'h0030, 32'h1, 4'h5}) begin
            n_fail++; $display("FAIL wfirst_lb: got %b/%h/%h/%h expected 1/0030/00000001/5",
                lb_wen, lb_waddr, lb_wdata, lb_wstrb); end
        lb_wready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (lb_wen) wen_cycles++;
            tick();
        end
        n_checks++; if (wen_cycles !== 1) begin
            n_fail++; $display("FAIL wfirst_count: got %0d lb writes expected 1", wen_cycles); end
    endtask

    task automatic test_read_wait();
        int ren_cycles = 0;
        idle_inputs();
        araddr = 16'h0030; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        n_checks++; if ({lb_ren, arready, lb_raddr} !== {2'b10, 16'h0030}) begin
            n_fail++; $display("FAIL rd_req: got ren=%b arready=%b raddr=%h expected 1/0/0030",
                lb_ren, arready, lb_raddr); end
        for (int i = 0; i < 3; i++) begin
            if (lb_ren) ren_cycles++;
            if (i == 2) begin lb_rvalid = 1'b1; lb_rdata = 32'h0000DEAD; end
            tick();
        end
        lb_rvalid = 1'b0; lb_rdata = 32'hFFFFFFFF;
        n_checks++; if (ren_cycles !== 3) begin
            n_fail++; $display("FAIL rd_ren_cycles: got %0d expected 3", ren_cycles); end
        n_checks++; if ({lb_ren, rvalid, rresp, rdata} !== {2'b01, 2'b00, 32'h0000DEAD}) begin
            n_fail++; $display("FAIL rd_resp: got ren=%b rvalid=%b rresp=%b rdata=%h expected 0/1/00/0000dead",
                lb_ren, rvalid, rresp, rdata); end
        tick();
        n_checks++; if ({rvalid, arready, rdata} !== {2'b01, 32'h0000DEAD}) begin
            n_fail++; $display("FAIL rd_hold: got rvalid=%b arready=%b rdata=%h expected 0/1/0000dead",
                rvalid, arready, rdata); end
    endtask

    task automatic test_backpressure();
        idle_inputs(); bready = 1'b0; lb_wready = 1'b1;
        awaddr = 16'h0034; awvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({bvalid, awready, wready} !== 3'b100) begin
                n_fail++; $display("FAIL bp_hold%0d: got bvalid/awready/wready=%b expected 100",
                    i, {bvalid, awready, wready}); end
            tick();
        end
        bready = 1'b1;
        tick();
        n_checks++; if ({bvalid, awready, wready} !== 3'b011) begin
            n_fail++; $display("FAIL bp_release: got %b expected 011", {bvalid, awready, wready}); end
    endtask

    task automatic test_concurrent();
        idle_inputs();
        awaddr = 16'h0040; awvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'h3; wvalid = 1'b1;
        araddr = 16'h0044; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        n_checks++; if ({lb_wen, lb_ren, lb_waddr, lb_raddr} !== {2'b11, 16'h0040, 16'h0044}) begin
            n_fail++; $display("FAIL cc_lb: got wen=%b ren=%b waddr=%h raddr=%h expected 1/1/0040/0044",
                lb_wen, lb_ren, lb_waddr, lb_raddr); end
        lb_wready = 1'b1; lb_rvalid = 1'b1; lb_rdata = 32'h12345678;
        tick();
        lb_wready = 1'b0; lb_rvalid = 1'b0;
        n_checks++; if ({bvalid, rvalid, bresp, rresp, rdata} !== {2'b11, 4'b0000, 32'h12345678}) begin
            n_fail++; $display("FAIL cc_resp: got bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h expected 1/1/00/00/12345678",
                bvalid, rvalid, bresp, rresp, rdata); end
        tick();
        // Local-bus strobes with no request outstanding must be ignored
        lb_wready = 1'b1; lb_rvalid = 1'b1;
        repeat (2) tick();
        n_checks++; if ({bvalid, rvalid, lb_wen, lb_ren} !== 4'b0000) begin
            n_fail++; $display("FAIL cc_ignore: got %b expected 0000", {bvalid, rvalid, lb_wen, lb_ren}); end
        idle_inputs();
    endtask

`ifdef AXIL2LB_TIMEOUT_EN
    task automatic test_timeout();
        int cnt = 0;
        int guard = 0;
        idle_inputs();
        awaddr = 16'h0050; awvalid = 1'b1; wdata = 32'h000000A5; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && guard < 50) begin
            if (lb_wen) cnt++;
            tick(); guard++;
        end
        n_checks++; if ({bvalid, bresp, lb_wen} !== 4'b1100 || cnt !== 8) begin
            n_fail++; $display("FAIL to_write: got bvalid=%b bresp=%b wen=%b wen_cycles=%0d expected 1/10/0/8",
                bvalid, bresp, lb_wen, cnt); end
        tick();
        cnt = 0; guard = 0;
        araddr = 16'h0060; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        while (!rvalid && guard < 50) begin
            if (lb_ren) cnt++;
            tick(); guard++;
        end
        n_checks++; if ({rvalid, rresp, rdata} !== {3'b110, 32'h0} || cnt !== 8) begin
            n_fail++; $display("FAIL to_read: got rvalid=%b rresp=%b rdata=%h ren_cycles=%0d expected 1/10/00000000/8",
                rvalid, rresp, rdata, cnt); end
        tick();
        // Completion on the final allowed cycle still gives OKAY
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (7) tick();
        lb_wready = 1'b1;
        tick();
        lb_wready = 1'b0;
        n_checks++; if ({bvalid, bresp} !== 3'b100) begin
            n_fail++; $display("FAIL to_edge: got bvalid=%b bresp=%b expected 1/00", bvalid, bresp); end
        tick();
    endtask
`endif

    task automatic test_reset_mid_read();
        idle_inputs();
        araddr = 16'h0044; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        n_checks++; if ({lb_ren, lb_raddr} !== {1'b1, 16'h0044}) begin
            n_fail++; $display("FAIL rst_mid_pre: got ren=%b raddr=%h expected 1/0044", lb_ren, lb_raddr); end
        rst = 1'b1;
        tick();
        n_checks++; if ({awready, wready, bvalid, arready, rvalid, lb_wen, lb_ren} !== 7'b0 ||
                        {lb_raddr, rdata, rresp} !== '0) begin
            n_fail++; $display("FAIL rst_mid_zero: got ctl=%b raddr=%h rdata=%h rresp=%b expected all 0",
                {awready, wready, bvalid, arready, rvalid, lb_wen, lb_ren}, lb_raddr, rdata, rresp); end
        rst = 1'b0; lb_rvalid = 1'b1; lb_rdata = 32'h55AA55AA;
        tick();
        lb_rvalid = 1'b0;
        repeat (3) tick();
        n_checks++; if ({rvalid, lb_ren, arready} !== 3'b001) begin
            n_fail++; $display("FAIL rst_mid_after: got rvalid/ren/arready=%b expected 001",
                {rvalid, lb_ren, arready}); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_w_before_aw();
        test_read_wait();
        test_backpressure();
        test_concurrent();
`ifdef AXIL2LB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
